bus_sequencer: RTL

- Sits directly upstream of memory_bus, between the F100-L core and the bank-decoded memory system.
- Converts single-cycle CPU requests (req/ready) into properly timed memory_bus cycles.
- Inserts per-bank wait states, strobes write_enable for exactly one clock, registers read data and returns a one-cycle valid pulse.
- Enables future slow (SPI EEPROM) banks by changing only wait parameters.

---
 rtl/bus_pkg.sv | 34 +++
 rtl/bus_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-to-memory_bus sequencer:
// bank codes, sequencer states and the per-bank wait lookup.
package bus_pkg;

    localparam logic [1:0] BANK_RAM    = 2'b00;
    localparam logic [1:0] BANK_ROM    = 2'b01;
    localparam logic [1:0] BANK_PERIPH = 2'b10;
    localparam logic [1:0] BANK_BRAM   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Wait values come from the instantiating module's parameters.
    function automatic int unsigned bank_wait(
        input logic [1:0]  bank,
        input int unsigned w_ram,
        input int unsigned w_rom,
        input int unsigned w_periph,
        input int unsigned w_bram
    );
        int unsigned w;
        case (bank)
            BANK_RAM:    w = w_ram;
            BANK_ROM:    w = w_rom;
            BANK_PERIPH: w = w_periph;
            default:     w = w_bram;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bus_sequencer.sv
// Turns single-cycle CPU requests into timed memory_bus cycles
// with per-bank wait states and a one-cycle completion pulse.
module bus_sequencer
    import bus_pkg::*;
#(
    parameter int unsigned WAIT_RAM    = 1,
    parameter int unsigned WAIT_ROM    = 1,
    parameter int unsigned WAIT_PERIPH = 2,
    parameter int unsigned WAIT_BRAM   = 1,
    parameter int unsigned WAIT_BITS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_valid,
    output logic [15:0] cpu_rdata,
    output logic [15:0] bus_address,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    output logic        bus_enable,
    output logic        write_enable,
    input  logic        fault_clear,
    output logic        rom_write_fault
);

    localparam int unsigned WAIT_MAX = (1 << WAIT_BITS) - 1;

    state_t               state;
    logic                 wr_q;
    logic [1:0]           bank_q;
    logic [WAIT_BITS-1:0] cnt;
    logic [WAIT_BITS-1:0] load_val;
    int unsigned          wait_sel;

    // Wait count for the requested bank, saturated so it never wraps.
    always_comb begin
        wait_sel = bank_wait(cpu_address[14:13], WAIT_RAM, WAIT_ROM,
                             WAIT_PERIPH, WAIT_BRAM);
        if (wait_sel > WAIT_MAX)
            load_val = WAIT_BITS'(WAIT_MAX);
        else
            load_val = WAIT_BITS'(wait_sel);
    end

    // Sequencer FSM; every bus/CPU output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            wr_q            <= 1'b0;
            bank_q          <= BANK_RAM;
            cnt             <= '0;
            cpu_ready       <= 1'b1;
            cpu_valid       <= 1'b0;
            cpu_rdata       <= '0;
            bus_address     <= '0;
            bus_wdata       <= '0;
            bus_enable      <= 1'b0;
            write_enable    <= 1'b0;
            rom_write_fault <= 1'b0;
        end else begin
            if (fault_clear)
                rom_write_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        state        <= ACCESS;
                        bus_address  <= cpu_address;
                        bus_wdata    <= cpu_wdata;
                        wr_q         <= cpu_write;
                        bank_q       <= cpu_address[14:13];
                        cnt          <= load_val;
                        cpu_ready    <= 1'b0;
                        bus_enable   <= 1'b1;
                        write_enable <= cpu_write &&
                                        (cpu_address[14:13] != BANK_ROM);
                    end
                end
                ACCESS: begin
                    write_enable <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= RESP;
                        bus_enable <= 1'b0;
                        cpu_valid  <= 1'b1;
                        if (!wr_q)
                            cpu_rdata <= bus_rdata;
                        if (wr_q && bank_q == BANK_ROM)
                            rom_write_fault <= 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    cpu_valid <= 1'b0;
                    cpu_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
